// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the write-back port arbiter: FU result payload, completion port, sizing.
package wb_port_arbiter_pkg;

  localparam int unsigned NR_WB_REQ       = 5;
  localparam int unsigned NR_WB_PORTS_ARB = 2;
  localparam int unsigned WB_CNT_W        = 32;
  localparam int unsigned TRANS_ID_BITS   = 4;
  localparam int unsigned XLEN            = 32;

  typedef logic [NR_WB_REQ-1:0] wb_req_vec_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          result;
  } fu_output_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic                     valid;
  } completion_port_t;

  // Index width that stays legal for single-entry vectors.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_multi_grant.sv
// Combinational round-robin picker: grants up to NB_PORTS valid requesters scanning from ptr_i.
module wb_port_arbiter_rr_multi_grant
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ   = NR_WB_REQ,
  parameter int unsigned NB_PORTS = NR_WB_PORTS_ARB,
  parameter int unsigned PTR_W    = idx_w(NB_REQ),
  parameter int unsigned PORT_W   = idx_w(NB_PORTS)
) (
  input  logic [NB_REQ-1:0]               valid_i,
  input  logic [PTR_W-1:0]                ptr_i,
  output logic [NB_REQ-1:0]               grant_o,
  output logic [NB_PORTS-1:0][PTR_W-1:0]  port_idx_o,
  output logic [NB_PORTS-1:0]             port_valid_o,
  output logic [PTR_W-1:0]                next_ptr_o
);

  int unsigned cand;
  int unsigned n_granted;

  // k-th valid requester found in scan order lands on port k.
  always_comb begin
    grant_o      = '0;
    port_idx_o   = '0;
    port_valid_o = '0;
    next_ptr_o   = ptr_i;
    cand         = 0;
    n_granted    = 0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NB_REQ) cand = cand - NB_REQ;
      if (valid_i[PTR_W'(cand)] && (n_granted < NB_PORTS)) begin
        grant_o[PTR_W'(cand)]           = 1'b1;
        port_idx_o[PORT_W'(n_granted)]   = PTR_W'(cand);
        port_valid_o[PORT_W'(n_granted)] = 1'b1;
        next_ptr_o = (cand == NB_REQ - 1) ? '0 : PTR_W'(cand + 1);
        n_granted  = n_granted + 1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares NB_PORTS write-back ports among NB_REQ FU result streams via one-entry holds.
// Optional conflict perf counter enabled by defining WB_ARB_PERF_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ   = NR_WB_REQ,
  parameter int unsigned NB_PORTS = NR_WB_PORTS_ARB,
  parameter int unsigned CNT_W    = WB_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  fu_output_t            req_i       [NB_REQ],
  input  logic [NB_REQ-1:0]     req_valid_i,
  output logic [NB_REQ-1:0]     req_ready_o,
  input  logic                  flush_i,
  output fu_output_t            wb_o        [NB_PORTS],
  output logic [NB_PORTS-1:0]   wb_valid_o,
  output completion_port_t      compl_o     [NB_PORTS],
  output logic [CNT_W-1:0]      conflict_o
);

  localparam int unsigned PTR_W = idx_w(NB_REQ);

  fu_output_t                    hold_q [NB_REQ];
  logic [NB_REQ-1:0]             hold_valid_q, hold_valid_d;
  logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NB_REQ-1:0]             grant;
  logic [NB_REQ-1:0]             accept;
  logic [NB_PORTS-1:0][PTR_W-1:0] port_idx;
  logic [NB_PORTS-1:0]           port_valid;
  logic [PTR_W-1:0]              next_ptr;

  wb_port_arbiter_rr_multi_grant #(
    .NB_REQ   (NB_REQ),
    .NB_PORTS (NB_PORTS),
    .PTR_W    (PTR_W)
  ) u_pick (
    .valid_i      (hold_valid_q),
    .ptr_i        (rr_ptr_q),
    .grant_o      (grant),
    .port_idx_o   (port_idx),
    .port_valid_o (port_valid),
    .next_ptr_o   (next_ptr)
  );

  // A slot frees up in the same cycle its hold is being drained.
  always_comb begin
    req_ready_o = '0;
    if (!rst && !flush_i) req_ready_o = ~hold_valid_q | grant;
  end

  assign accept = req_valid_i & req_ready_o;

  always_comb begin
    hold_valid_d = (hold_valid_q & ~grant) | accept;
    if (flush_i) hold_valid_d = '0;
    rr_ptr_d = (|grant) ? next_ptr : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // Payload needs no reset: it is qualified by hold_valid_q.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (accept[i]) hold_q[i] <= req_i[i];
    end
  end

  assign wb_valid_o = port_valid;

  always_comb begin
    for (int unsigned k = 0; k < NB_PORTS; k++) begin
      wb_o[k]          = '0;
      compl_o[k]       = '0;
      if (port_valid[k]) wb_o[k] = hold_q[port_idx[k]];
      compl_o[k].id    = wb_o[k].id;
      compl_o[k].valid = port_valid[k];
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [CNT_W-1:0] conflict_q;

  // Saturating count of cycles with more full holds than ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else if ((32'($countones(hold_valid_q)) > NB_PORTS) && (conflict_q != '1)) begin
      conflict_q <= conflict_q + CNT_W'(1);
    end
  end

  assign conflict_o = conflict_q;
`else
  assign conflict_o = '0;
`endif

`ifndef SYNTHESIS
  // Each granted requester appears on exactly one port and ports fill from 0 upward.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($countones(grant) == $countones(port_valid));
      for (int unsigned k = 0; k < NB_PORTS; k++) begin
        assert (!port_valid[k] || grant[port_idx[k]]);
        if (k > 0) assert (!port_valid[k] || port_valid[k-1]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter; conflict expectations follow WB_ARB_PERF_EN.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int unsigned NREQ  = NR_WB_REQ;
  localparam int unsigned NPORT = NR_WB_PORTS_ARB;
  localparam logic [XLEN-1:0] RES_TAG = 32'hA5A5_0000;
  localparam int NVEC = 26;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  fu_output_t           req_i [NREQ];
  wb_req_vec_t          req_valid = '0;
  wb_req_vec_t          req_ready;
  fu_output_t           wb [NPORT];
  logic [NPORT-1:0]     wb_valid;
  completion_port_t     compl [NPORT];
  logic [WB_CNT_W-1:0]  conflict;

  int checks = 0;
  int errors = 0;
  int unsigned conf_model = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .NB_REQ   (NREQ),
    .NB_PORTS (NPORT),
    .CNT_W    (WB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .flush_i     (flush),
    .wb_o        (wb),
    .wb_valid_o  (wb_valid),
    .compl_o     (compl),
    .conflict_o  (conflict)
  );

  typedef struct {
    logic        r;
    logic        f;
    wb_req_vec_t v;
    logic [3:0]  base;
    wb_req_vec_t rdy;
    logic [1:0]  wbv;
    logic [3:0]  id0;
    logic [3:0]  id1;
    int unsigned hv;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic f, input wb_req_vec_t v,
                              input logic [3:0] base, input wb_req_vec_t rdy,
                              input logic [1:0] wbv, input logic [3:0] id0,
                              input logic [3:0] id1, input int unsigned hv);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.base = base; t.rdy = rdy;
    t.wbv = wbv; t.id0 = id0; t.id1 = id1; t.hv = hv;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Requester i presents id = base + i and a tagged result derived from it.
  task automatic drive(input logic r, input logic f, input wb_req_vec_t v, input logic [3:0] base);
    logic [TRANS_ID_BITS-1:0] idv;
    rst = r;
    flush = f;
    req_valid = v;
    for (int i = 0; i < int'(NREQ); i++) begin
      idv = base + TRANS_ID_BITS'(i);
      req_i[i].id = idv;
      req_i[i].result = RES_TAG | XLEN'(idv);
    end
  endtask

  task automatic check_all(input string tag, input wb_req_vec_t exp_rdy, input logic [1:0] exp_v,
                           input logic [3:0] e0, input logic [3:0] e1, input int unsigned exp_conf);
    logic [3:0] eid [2];
    logic [XLEN-1:0] eres;
    eid[0] = e0;
    eid[1] = e1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    chk({tag, "_wbv"}, 64'(wb_valid), 64'(exp_v));
    for (int k = 0; k < int'(NPORT); k++) begin
      eres = exp_v[k] ? (RES_TAG | XLEN'(eid[k])) : '0;
      chk($sformatf("%s_p%0d_id", tag, k), 64'(wb[k].id), 64'(exp_v[k] ? eid[k] : 4'd0));
      chk($sformatf("%s_p%0d_res", tag, k), 64'(wb[k].result), 64'(eres));
      chk($sformatf("%s_p%0d_cid", tag, k), 64'(compl[k].id), 64'(exp_v[k] ? eid[k] : 4'd0));
      chk($sformatf("%s_p%0d_cv", tag, k), 64'(compl[k].valid), 64'(exp_v[k]));
    end
    chk({tag, "_conflict"}, 64'(conflict), 64'(exp_conf));
  endtask

  function automatic int unsigned conf_exp();
`ifdef WB_ARB_PERF_EN
    return conf_model;
`else
    return 0;
`endif
  endfunction

  initial begin
    //              r     f     valid      base   ready      wbv    id0    id1    holds
    vecs[0]  = mk(1'b1, 1'b0, 5'b00000, 4'd0,  5'b00000, 2'b00, 4'd0,  4'd0,  0);
    vecs[1]  = mk(1'b0, 1'b0, 5'b00100, 4'd5,  5'b11111, 2'b00, 4'd0,  4'd0,  0);
    vecs[2]  = mk(1'b0, 1'b0, 5'b00000, 4'd0,  5'b11111, 2'b01, 4'd7,  4'd0,  1);
    vecs[3]  = mk(1'b0, 1'b0, 5'b10011, 4'd0,  5'b11111, 2'b00, 4'd0,  4'd0,  0);
    vecs[4]  = mk(1'b1, 1'b0, 5'b00000, 4'd0,  5'b00000, 2'b00, 4'd0,  4'd0,  0);
    vecs[5]  = mk(1'b0, 1'b0, 5'b00000, 4'd0,  5'b11111, 2'b00, 4'd0,  4'd0,  0);
    vecs[6]  = mk(1'b0, 1'b0, 5'b00111, 4'd8,  5'b11111, 2'b00, 4'd0,  4'd0,  0);
    vecs[7]  = mk(1'b0, 1'b0, 5'b00100, 4'd0,  5'b11011, 2'b11, 4'd8,  4'd9,  3);
    vecs[8]  = mk(1'b0, 1'b0, 5'b00100, 4'd0,  5'b11111, 2'b01, 4'd10, 4'd0,  1);
    vecs[9]  = mk(1'b0, 1'b0, 5'b00000, 4'd0,  5'b11111, 2'b01, 4'd2,  4'd0,  1);
    vecs[10] = mk(1'b1, 1'b0, 5'b00000, 4'd0,  5'b00000, 2'b00, 4'd0,  4'd0,  0);
    vecs[11] = mk(1'b0, 1'b0, 5'b11111, 4'd0,  5'b11111, 2'b00, 4'd0,  4'd0,  0);
    vecs[12] = mk(1'b0, 1'b0, 5'b11111, 4'd5,  5'b00011, 2'b11, 4'd0,  4'd1,  5);
    vecs[13] = mk(1'b0, 1'b0, 5'b11111, 4'd10, 5'b01100, 2'b11, 4'd2,  4'd3,  5);
    vecs[14] = mk(1'b0, 1'b0, 5'b11111, 4'd15, 5'b10001, 2'b11, 4'd4,  4'd5,  5);
    vecs[15] = mk(1'b0, 1'b0, 5'b11111, 4'd4,  5'b00110, 2'b11, 4'd6,  4'd12, 5);
    vecs[16] = mk(1'b0, 1'b0, 5'b00000, 4'd0,  5'b11000, 2'b11, 4'd13, 4'd3,  5);
    vecs[17] = mk(1'b0, 1'b0, 5'b00000, 4'd0,  5'b11011, 2'b11, 4'd15, 4'd5,  3);
    vecs[18] = mk(1'b0, 1'b0, 5'b00000, 4'd0,  5'b11111, 2'b01, 4'd6,  4'd0,  1);
    vecs[19] = mk(1'b0, 1'b0, 5'b01001, 4'd0,  5'b11111, 2'b00, 4'd0,  4'd0,  0);
    vecs[20] = mk(1'b0, 1'b0, 5'b01001, 4'd8,  5'b11111, 2'b11, 4'd3,  4'd0,  2);
    vecs[21] = mk(1'b0, 1'b1, 5'b11111, 4'd0,  5'b00000, 2'b11, 4'd11, 4'd8,  2);
    vecs[22] = mk(1'b0, 1'b0, 5'b00000, 4'd0,  5'b11111, 2'b00, 4'd0,  4'd0,  0);
    vecs[23] = mk(1'b0, 1'b0, 5'b00111, 4'd0,  5'b11111, 2'b00, 4'd0,  4'd0,  0);
    vecs[24] = mk(1'b0, 1'b0, 5'b00000, 4'd0,  5'b11110, 2'b11, 4'd1,  4'd2,  3);
    vecs[25] = mk(1'b0, 1'b0, 5'b00000, 4'd0,  5'b11111, 2'b01, 4'd0,  4'd0,  1);

    drive(1'b1, 1'b0, '0, 4'd0);

    for (int n = 0; n < NVEC; n++) begin
      @(posedge clk);
      #1;
      drive(vecs[n].r, vecs[n].f, vecs[n].v, vecs[n].base);
      @(negedge clk);
      if (vecs[n].r) conf_model = 0;
      check_all($sformatf("v%0d", n), vecs[n].rdy, vecs[n].wbv, vecs[n].id0, vecs[n].id1, conf_exp());
      if (!vecs[n].r && vecs[n].hv > NPORT) conf_model++;
    end

    // Reset asserted between edges with every hold full: outputs must drop at once.
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 5'b11111, 4'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 5'b00000, 4'd0);
    #2;
    check_all("full", 5'b00110, 2'b11, 4'd1, 4'd2, conf_exp());
    rst = 1'b1;
    #1;
    conf_model = 0;
    check_all("async_rst", 5'b00000, 2'b00, 4'd0, 4'd0, conf_exp());
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all("post_rst", 5'b11111, 2'b00, 4'd0, 4'd0, conf_exp());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
